rs: RTL and testbench
=====================

RS -- requirements
Module: rs

Interface
REQ-001 SHALL expose parameter RS_SIZE, default 16, number of table entries.
REQ-002 SHALL expose parameter NUM_FU, default 8, number of issue slots.
REQ-003 SHALL expose parameter NUM_PHYS_REG, default 64, number of physical registers; PHYS_REG = {ready bit (MSB), tag [$clog2(NUM_PHYS_REG)-1:0]}.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 enable  in  1  gates dispatch and issue.
REQ-007 CAM_en  in  1  CDB broadcast valid.
REQ-008 CDB_in  in  PHYS_REG  broadcast tag; only tag bits are compared.
REQ-009 dispatch_valid  in  1  inst_in holds a new instruction.
REQ-010 inst_in  in  RS_ROW_T  {inst (decoded), T dest, T1 src1, T2 src2, busy}.
REQ-011 LSQ_busy  in  2  bit0 = load queue busy, bit1 = store queue busy.
REQ-012 rs_table_out  out  RS_ROW_T[RS_SIZE]  registered table contents.
REQ-013 issue_next  out  RS_ROW_T[NUM_FU]  registered rows issued at the last edge.
REQ-014 issue_cnt  out  $clog2(NUM_FU)  number of valid issue_next slots.
REQ-015 rs_full  out  1  all RS_SIZE entries busy.

Function
REQ-016 An entry is valid iff its busy=1; a free entry SHALL be all-zero.
REQ-017 Dispatch: at an edge with enable=1, dispatch_valid=1, inst_in.busy=1 and rs_full=0, inst_in SHALL be written with busy=1 into the lowest-index free entry, as computed from the pre-edge table.
REQ-018 Dispatch while rs_full=1 SHALL be dropped; the table SHALL be unchanged by it.
REQ-019 Operand ready = MSB of T1/T2; an entry SHALL be issue-eligible when busy=1 and both ready bits are 1 in the pre-edge table.
REQ-020 An entry SHALL be issue-eligible no earlier than one edge after it was written.
REQ-021 An entry with inst.rd_mem=1 SHALL NOT issue while LSQ_busy[0]=1.
REQ-022 An entry with inst.wr_mem=1 SHALL NOT issue while LSQ_busy[1]=1.
REQ-023 Issue: at an edge with enable=1, eligible entries SHALL be selected lowest index first, up to min(NUM_FU, 2^width(issue_cnt)-1).
REQ-024 Selected rows SHALL be copied unchanged (busy=1) into issue_next[0..n-1]; the remaining slots SHALL be all-zero; issue_cnt SHALL be n.
REQ-025 Issued entries SHALL be cleared to zero at the same edge.
REQ-026 A slot freed by issue at an edge SHALL NOT be reused by a dispatch at that same edge.
REQ-027 Any edge that issues nothing (enable=0 or no eligible entry) SHALL set issue_next to all-zero and issue_cnt to 0.
REQ-028 Wakeup: at every edge with CAM_en=1, independent of enable, each busy entry whose T1 or T2 tag equals the CDB_in tag SHALL have that operand's ready bit set.
REQ-029 Wakeup SHALL also apply to an instruction being dispatched at the same edge.
REQ-030 Wakeup SHALL take effect for issue at the following edge, not the same edge.
REQ-031 Wakeup SHALL NOT modify T and SHALL NOT modify an operand that is already ready.
REQ-032 rs_full SHALL be combinational from the registered table (count of busy entries == RS_SIZE).
REQ-033 With enable=0, dispatch and issue SHALL be suppressed; wakeup continues; table otherwise held.

Reset
REQ-034 While reset=1, immediately and asynchronously, rs_table_out and issue_next SHALL be all-zero, issue_cnt=0 and rs_full=0.
REQ-035 reset SHALL override all other inputs, including mid-operation; pending issue and dispatch SHALL be discarded.
REQ-036 At the first edge after reset deasserts, normal operation SHALL resume with an empty table.

Verification
REQ-037 Assert reset with enable=1 and dispatch_valid=1 -> all outputs zero during reset and one cycle after release.
REQ-038 Dispatch ADDQ with T=3, T1=ready|2, T2=ready|1 -> next cycle: exactly one busy entry equal to inst_in, issue_next zero, issue_cnt=0; following cycle: table empty, issue_next[0]=inst_in, issue_cnt=1; third cycle: issue_next zero.
REQ-039 Dispatch with T1=5 (not ready), T2 ready -> the entry stays and never issues; then CAM_en=1, CDB_in=5 -> T1 ready bit set after that edge, issue one edge later.
REQ-040 Dispatch RS_SIZE non-ready instructions -> rs_full=1; one extra dispatch is dropped (entry count unchanged); a wakeup/issue then frees a slot and rs_full drops.
REQ-041 Ready load with LSQ_busy=2'b01 -> held in the table; clearing LSQ_busy -> issues next edge; a ready store with LSQ_busy=2'b10 -> held likewise.
REQ-042 Assert reset while entries are busy and the issue stage is occupied -> table, issue_next and issue_cnt zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rs.sv
// Reservation station: an in-order free-slot dispatch table with CDB operand
// wakeup and oldest-index-first multi-issue into a registered issue bundle.
package rs_pkg;
    localparam int PHYS_REGS = 64;
    localparam int PHYS_W    = $clog2(PHYS_REGS) + 1;

    typedef logic [PHYS_W-1:0] phys_reg_t;

    typedef struct packed {
        logic [7:0] opcode;
        logic       rd_mem;
        logic       wr_mem;
    } inst_t;

    typedef struct packed {
        inst_t     inst;
        phys_reg_t T;
        phys_reg_t T1;
        phys_reg_t T2;
        logic      busy;
    } rs_row_t;
endpackage

module rs_wakeup
    import rs_pkg::*;
#(
    parameter int TAG_W = PHYS_W - 1
) (
    input  logic             cam_en,
    input  logic [TAG_W-1:0] cdb_tag,
    input  rs_row_t          row_in,
    output rs_row_t          row_out
);
    always_comb begin
        row_out = row_in;
        if (cam_en && row_in.busy) begin
            if (row_in.T1[TAG_W-1:0] == cdb_tag) row_out.T1[PHYS_W-1] = 1'b1;
            if (row_in.T2[TAG_W-1:0] == cdb_tag) row_out.T2[PHYS_W-1] = 1'b1;
        end
    end
endmodule

module rs
    import rs_pkg::*;
#(
    parameter int  RS_SIZE      = 16,
    parameter int  NUM_FU       = 8,
    parameter int  NUM_PHYS_REG = 64,
    localparam int CNT_W        = $clog2(NUM_FU)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     CAM_en,
    input  phys_reg_t                CDB_in,
    input  logic                     dispatch_valid,
    input  rs_row_t                  inst_in,
    input  logic [1:0]               LSQ_busy,
    output rs_row_t [RS_SIZE-1:0]    rs_table_out,
    output rs_row_t [NUM_FU-1:0]     issue_next,
    output logic    [CNT_W-1:0]      issue_cnt,
    output logic                     rs_full
);
    localparam int TAG_W   = $clog2(NUM_PHYS_REG);
    // issue_cnt cannot represent NUM_FU itself when NUM_FU is a power of two
    localparam int MAX_ISS = (NUM_FU < (2**CNT_W - 1)) ? NUM_FU : (2**CNT_W - 1);

    rs_row_t [RS_SIZE-1:0] tbl_pre_wk, tbl_nx;
    rs_row_t [NUM_FU-1:0]  iss_nx;
    logic    [CNT_W-1:0]   cnt_nx;
    logic    [RS_SIZE-1:0] busy, elig, sel, free_oh;
    logic                  do_disp, found;
    logic                  unused_cdb;

    assign unused_cdb = ^CDB_in[PHYS_W-1:TAG_W];

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            busy[i] = rs_table_out[i].busy;
            elig[i] = rs_table_out[i].busy
                    & rs_table_out[i].T1[PHYS_W-1] & rs_table_out[i].T2[PHYS_W-1]
                    & ~(rs_table_out[i].inst.rd_mem & LSQ_busy[0])
                    & ~(rs_table_out[i].inst.wr_mem & LSQ_busy[1]);
        end
    end

    assign rs_full = &busy;
    assign do_disp = enable & dispatch_valid & inst_in.busy & ~rs_full;

    always_comb begin
        sel    = '0;
        iss_nx = '0;
        cnt_nx = '0;
        if (enable) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (elig[i] && (cnt_nx < CNT_W'(MAX_ISS))) begin
                    sel[i]         = 1'b1;
                    iss_nx[cnt_nx] = rs_table_out[i];
                    cnt_nx         = cnt_nx + 1'b1;
                end
            end
        end
    end

    // Free slot comes from the pre-edge table, so a slot vacated by issue is not reused this edge
    always_comb begin
        free_oh = '0;
        found   = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!busy[i] && !found) begin
                free_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            tbl_pre_wk[i] = sel[i] ? '0 : rs_table_out[i];
            if (do_disp && free_oh[i]) tbl_pre_wk[i] = inst_in;
        end
    end

    // Wakeup acts on the post-dispatch table so a same-edge dispatch also catches the broadcast
    for (genvar g = 0; g < RS_SIZE; g++) begin : g_wk
        rs_wakeup #(.TAG_W(TAG_W)) u_wk (
            .cam_en  (CAM_en),
            .cdb_tag (CDB_in[TAG_W-1:0]),
            .row_in  (tbl_pre_wk[g]),
            .row_out (tbl_nx[g])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rs_table_out <= '0;
            issue_next   <= '0;
            issue_cnt    <= '0;
        end else begin
            rs_table_out <= tbl_nx;
            issue_next   <= iss_nx;
            issue_cnt    <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_rs.sv
// Directed bench for rs: reset, single issue, wakeup, full/drop, LSQ gating,
// enable hold, slot-reuse ordering and asynchronous reset.
module tb_rs;
    import rs_pkg::*;

    localparam int RS_SIZE = 16;
    localparam int NUM_FU  = 8;

    logic                  clock = 1'b0;
    logic                  reset, enable, CAM_en, dispatch_valid;
    phys_reg_t             CDB_in;
    rs_row_t               inst_in;
    logic [1:0]            LSQ_busy;
    rs_row_t [RS_SIZE-1:0] rs_table_out;
    rs_row_t [NUM_FU-1:0]  issue_next;
    logic [2:0]            issue_cnt;
    logic                  rs_full;

    int n_chk = 0;
    int n_err = 0;

    rs #(.RS_SIZE(RS_SIZE), .NUM_FU(NUM_FU), .NUM_PHYS_REG(64)) dut (
        .clock(clock), .reset(reset), .enable(enable), .CAM_en(CAM_en),
        .CDB_in(CDB_in), .dispatch_valid(dispatch_valid), .inst_in(inst_in),
        .LSQ_busy(LSQ_busy), .rs_table_out(rs_table_out), .issue_next(issue_next),
        .issue_cnt(issue_cnt), .rs_full(rs_full)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic rs_row_t mk(input logic [7:0] op, input logic rd, input logic wr,
                                   input phys_reg_t t, input phys_reg_t t1, input phys_reg_t t2);
        rs_row_t r;
        r.inst.opcode = op;
        r.inst.rd_mem = rd;
        r.inst.wr_mem = wr;
        r.T    = t;
        r.T1   = t1;
        r.T2   = t2;
        r.busy = 1'b1;
        return r;
    endfunction

    function automatic int n_busy();
        int n = 0;
        for (int i = 0; i < RS_SIZE; i++) if (rs_table_out[i].busy) n++;
        return n;
    endfunction

    function automatic logic all_zero();
        return (rs_table_out == '0) && (issue_next == '0) && (issue_cnt == 3'd0) && !rs_full;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    rs_row_t a, b, c, ld, st, full0, xtra;

    initial begin
        a  = mk(8'h20, 1'b0, 1'b0, 7'd3, 7'h42, 7'h41);
        b  = mk(8'h21, 1'b0, 1'b0, 7'd4, 7'd5,  7'h41);
        ld = mk(8'h30, 1'b1, 1'b0, 7'd8, 7'h41, 7'h42);
        st = mk(8'h31, 1'b0, 1'b1, 7'd9, 7'h41, 7'h42);

        // reset held with dispatch pending
        reset = 1'b1; enable = 1'b1; dispatch_valid = 1'b1; inst_in = a;
        CAM_en = 1'b0; CDB_in = '0; LSQ_busy = 2'b00;
        repeat (2) tick();
        chk("reset_hold_zero", all_zero(), 1'b1);
        #1 reset = 1'b0;
        #1 chk("reset_release_zero", all_zero(), 1'b1);
        dispatch_valid = 1'b0;
        tick();
        chk("post_reset_empty", all_zero(), 1'b1);

        // single ready ADDQ: dispatch, issue, drain
        dispatch_valid = 1'b1; inst_in = a;
        tick();
        dispatch_valid = 1'b0;
        chk("addq_count", n_busy(), 1);
        chk("addq_row0", rs_table_out[0], a);
        chk("addq_no_issue", issue_cnt, 0);
        chk("addq_issue_zero", issue_next, '0);
        tick();
        chk("addq_tbl_empty", n_busy(), 0);
        chk("addq_issued", issue_next[0], a);
        chk("addq_cnt1", issue_cnt, 1);
        tick();
        chk("addq_drained", issue_next, '0);
        chk("addq_cnt0", issue_cnt, 0);

        // non-ready src1 waits for CDB tag 5
        dispatch_valid = 1'b1; inst_in = b;
        tick();
        dispatch_valid = 1'b0;
        repeat (2) tick();
        chk("wait_held", rs_table_out[0], b);
        chk("wait_no_issue", issue_cnt, 0);
        CAM_en = 1'b1; CDB_in = 7'd5;
        tick();
        CAM_en = 1'b0;
        chk("wake_T1", rs_table_out[0].T1, 7'h45);
        chk("wake_T_kept", rs_table_out[0].T, 7'd4);
        chk("wake_not_same_edge", issue_cnt, 0);
        tick();
        b.T1 = 7'h45;
        chk("wake_issue_cnt", issue_cnt, 1);
        chk("wake_issue_row", issue_next[0], b);
        chk("wake_tbl_empty", n_busy(), 0);

        // fill table, drop extra dispatch, then wake all and drain 7/7/2
        dispatch_valid = 1'b1;
        for (int i = 0; i < RS_SIZE; i++) begin
            inst_in = mk(8'h40, 1'b0, 1'b0, 7'(i), 7'd6, 7'h41);
            tick();
        end
        chk("full_flag", rs_full, 1'b1);
        chk("full_count", n_busy(), RS_SIZE);
        full0 = rs_table_out[RS_SIZE-1];
        xtra = mk(8'h41, 1'b0, 1'b0, 7'h3F, 7'h41, 7'h41);
        inst_in = xtra;
        tick();
        chk("drop_count", n_busy(), RS_SIZE);
        chk("drop_last_row", rs_table_out[RS_SIZE-1], full0);
        CAM_en = 1'b1; CDB_in = 7'd6;
        tick();
        CAM_en = 1'b0;
        chk("full_wake_T1", rs_table_out[0].T1, 7'h46);
        chk("full_wake_no_issue", issue_cnt, 0);
        chk("full_still_full", rs_full, 1'b1);
        tick();
        chk("drain1_cnt", issue_cnt, 7);
        chk("drain1_count", n_busy(), RS_SIZE - 7);
        chk("drain1_order", issue_next[6].T, 7'd6);
        chk("drain1_slot7_zero", issue_next[7], '0);
        chk("drain1_not_full", rs_full, 1'b0);
        dispatch_valid = 1'b0;
        tick();
        chk("drain2_cnt", issue_cnt, 7);
        chk("drain2_first", issue_next[0].T, 7'd7);
        tick();
        chk("drain3_cnt", issue_cnt, 2);
        chk("drain3_last", issue_next[1].T, 7'd15);
        chk("drain3_empty", n_busy(), 0);
        tick();

        // LSQ gating for load and store
        LSQ_busy = 2'b01; dispatch_valid = 1'b1; inst_in = ld;
        tick();
        dispatch_valid = 1'b0;
        tick();
        chk("ld_held", rs_table_out[0], ld);
        chk("ld_no_issue", issue_cnt, 0);
        LSQ_busy = 2'b00;
        tick();
        chk("ld_issued", issue_next[0], ld);
        LSQ_busy = 2'b10; dispatch_valid = 1'b1; inst_in = st;
        tick();
        dispatch_valid = 1'b0;
        tick();
        chk("st_held", rs_table_out[0], st);
        chk("st_no_issue", issue_cnt, 0);
        LSQ_busy = 2'b01;
        tick();
        chk("st_issued", issue_next[0], st);
        LSQ_busy = 2'b00;

        // enable=0 holds a ready entry
        dispatch_valid = 1'b1; inst_in = a;
        tick();
        dispatch_valid = 1'b0; enable = 1'b0;
        tick();
        chk("en0_held", rs_table_out[0], a);
        chk("en0_no_issue", issue_cnt, 0);
        enable = 1'b1;
        tick();
        chk("en1_issue", issue_next[0], a);

        // dispatch at an issuing edge lands above the slot being vacated
        c = mk(8'h50, 1'b0, 1'b0, 7'd11, 7'd12, 7'h41);
        dispatch_valid = 1'b1; inst_in = a;
        tick();
        inst_in = c;
        tick();
        dispatch_valid = 1'b0;
        chk("reuse_slot0_free", rs_table_out[0], '0);
        chk("reuse_slot1", rs_table_out[1], c);
        chk("reuse_issued", issue_next[0], a);

        // asynchronous reset mid-operation (c busy, issue stage occupied)
        #2 reset = 1'b1;
        #1 chk("async_reset_zero", all_zero(), 1'b1);
        #1 reset = 1'b0;
        tick();
        chk("async_post_empty", n_busy(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
